reg_write_arbiter: RTL and testbench

Round-robin write-port controller that shares one 32-bit storage register among several requesters. Each requester presents a request and a data word. The block picks one winner per arbitration slot, returns a one-hot grant, and loads the winner's word into the shared register. It sits between the pipeline stages that produce results and the register that holds the shared architectural value.

---
 rtl/reg_write_arbiter.sv | 109 ++++++++++
 tb/tb_reg_write_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin write-port controller for one shared register
module reg_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       q,
  output logic                   busy,
  output logic [1:0]             last_id
);

  typedef enum logic {ARB, WRITE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         ptr;
  logic [1:0]         ptr_nxt;
  logic [1:0]         win_id;
  logic [1:0]         win_id_nxt;
  logic [1:0]         last_id_nxt;
  logic [N_REQ-1:0]   gnt_nxt;
  logic               busy_nxt;
  logic [WIDTH-1:0]   q_nxt;

  logic [1:0]         rr_winner;
  logic               rr_found;
  logic [1:0]         rr_cand;

  logic [WIDTH-1:0]   word [N_REQ];

  // Split the packed write-data bus into one word per requester.
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign word[g] = wdata[g*WIDTH +: WIDTH];
  end

  // Round-robin search: first requesting index at or after ptr, wrapping.
  always_comb begin
    rr_winner = ptr;
    rr_found  = 1'b0;
    rr_cand   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rr_cand = ptr + 2'(i);
      if (!rr_found && req[rr_cand]) begin
        rr_winner = rr_cand;
        rr_found  = 1'b1;
      end
    end
  end

  // Next-state and next-output logic; everything holds unless a transition fires.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    win_id_nxt  = win_id;
    last_id_nxt = last_id;
    gnt_nxt     = gnt;
    busy_nxt    = busy;
    q_nxt       = q;
    case (state)
      ARB: begin
        if (rr_found) begin
          gnt_nxt            = '0;
          gnt_nxt[rr_winner] = 1'b1;
          busy_nxt           = 1'b1;
          win_id_nxt         = rr_winner;
          state_nxt          = WRITE;
        end
      end
      WRITE: begin
        // req is deliberately ignored here: the winner is written even if it dropped.
        q_nxt       = word[win_id];
        last_id_nxt = win_id;
        ptr_nxt     = win_id + 2'd1;
        gnt_nxt     = '0;
        busy_nxt    = 1'b0;
        state_nxt   = ARB;
      end
      default: begin
        state_nxt = ARB;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ARB;
      ptr     <= '0;
      win_id  <= '0;
      last_id <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      q       <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      win_id  <= win_id_nxt;
      last_id <= last_id_nxt;
      gnt     <= gnt_nxt;
      busy    <= busy_nxt;
      q       <= q_nxt;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed self-checking bench for reg_write_arbiter
module tb_reg_write_arbiter;

  logic         clock;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] wdata;
  logic [3:0]   gnt;
  logic [31:0]  q;
  logic         busy;
  logic [1:0]   last_id;

  int checks = 0;
  int errors = 0;

  reg_write_arbiter #(.N_REQ(4), .WIDTH(32)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .wdata   (wdata),
    .gnt     (gnt),
    .q       (q),
    .busy    (busy),
    .last_id (last_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle_outs(input string tag, input logic [31:0] exp_q, input logic [1:0] exp_id);
    check({tag, "_gnt"}, 32'(gnt), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_q"}, q, exp_q);
    check({tag, "_last_id"}, 32'(last_id), 32'(exp_id));
  endtask

  logic [31:0] exp_word;
  logic [3:0]  exp_gnt;

  initial begin
    reset = 1'b0;
    req   = 4'b0000;
    wdata = '0;
    #1;
    check_idle_outs("reset", 32'h0, 2'd0);
    step();
    step();
    reset = 1'b1;
    step();

    // Single requester 2
    wdata[2*32 +: 32] = 32'hDEADBEEF;
    wdata[3*32 +: 32] = 32'hCAFE0003;
    wdata[0*32 +: 32] = 32'hCAFE0000;
    req = 4'b0100;
    step();
    check("single_gnt", 32'(gnt), 32'h4);
    check("single_busy", 32'(busy), 32'h1);
    check("single_q_hold", q, 32'h0);
    step();
    check_idle_outs("single_done", 32'hDEADBEEF, 2'd2);
    req = 4'b0000;
    step();

    // Fairness after wrap: ptr is now 3
    req = 4'b1001;
    step();
    check("wrap_gnt_first", 32'(gnt), 32'h8);
    step();
    check("wrap_q_first", q, 32'hCAFE0003);
    check("wrap_id_first", 32'(last_id), 32'd3);
    step();
    check("wrap_gnt_second", 32'(gnt), 32'h1);
    step();
    check("wrap_q_second", q, 32'hCAFE0000);
    check("wrap_id_second", 32'(last_id), 32'd0);
    req = 4'b0000;
    step();

    // Return ptr to 0 with a reset pulse, then all requesters continuously
    reset = 1'b0;
    #2;
    reset = 1'b1;
    step();
    for (int i = 0; i < 4; i++) wdata[i*32 +: 32] = 32'h1111_1111 * (i + 1);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      exp_gnt = 4'b0001 << (k % 4);
      check("rr_gnt", 32'(gnt), 32'(exp_gnt));
      check("rr_busy", 32'(busy), 32'h1);
      step();
      exp_word = 32'h1111_1111 * ((k % 4) + 1);
      check_idle_outs("rr_done", exp_word, 2'(k % 4));
    end
    req = 4'b0000;
    step();

    // Drop in WRITE: ptr is 1 after granting 0
    wdata[1*32 +: 32] = 32'h0000_00A5;
    req = 4'b0010;
    step();
    check("drop_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    step();
    check_idle_outs("drop_done", 32'h0000_00A5, 2'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      check_idle_outs("drop_nogrant", 32'h0000_00A5, 2'd1);
    end

    // Reset during WRITE for requester 3
    req = 4'b1000;
    step();
    check("rst_gnt_before", 32'(gnt), 32'h8);
    reset = 1'b0;
    #1;
    check_idle_outs("rst_async", 32'h0, 2'd0);
    req = 4'b1010;
    step();
    check_idle_outs("rst_held", 32'h0, 2'd0);
    reset = 1'b1;
    step();
    check("rst_after_gnt", 32'(gnt), 32'h2);
    step();
    check_idle_outs("rst_after_q1", 32'h0000_00A5, 2'd1);
    step();
    check("rst_after_gnt3", 32'(gnt), 32'h8);
    req = 4'b0000;
    step();
    check_idle_outs("rst_after_q3", 32'h4444_4444, 2'd3);

    // Idle for 20 cycles
    for (int k = 0; k < 20; k++) begin
      step();
      check_idle_outs("idle", 32'h4444_4444, 2'd3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
